compute_s: RTL and testbench

//  Second IDCT matrix stage: computes the 8x8 block S = C^T * T, one MAC per clock.
//  T (32-bit signed) is read from the T dual-port RAM; S is written to port B of the S dual-port RAM.

---
 rtl/compute_s_pkg.sv | 48 ++++
 rtl/compute_s_coeff_rom.sv | 16 +
 rtl/compute_s.sv | 151 +++++++++++++++
 tb/tb_compute_s.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/compute_s_pkg.sv
// Shared types, constants and the DCT coefficient helper for the second IDCT
// matrix stage (S = C^T * T).
package compute_s_pkg;

  localparam int BLK_N      = 8;
  localparam int MAC_CYCLES = 512;
  localparam int PIPE_DEPTH = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_DONE
  } state_t;

  // C[k][i] = 2048*cos((2i+1)k*pi/16), truncated toward zero; row 0 is 1448.
  // The angle index is folded into the first quadrant so only 8 magnitudes are kept.
  function automatic logic signed [11:0] dctCoef(input logic [2:0] k, input logic [2:0] i);
    logic [6:0]  m;
    logic [4:0]  f;
    logic        neg;
    logic [11:0] mag;
    m   = 7'({3'd0, i, 1'b1} * {4'd0, k});
    f   = m[4:0];
    neg = 1'b0;
    if (f > 5'd16) f = 5'd0 - f;
    if (f > 5'd8) begin
      neg = 1'b1;
      f   = 5'd16 - f;
    end
    case (f)
      5'd1:    mag = 12'd2008;
      5'd2:    mag = 12'd1892;
      5'd3:    mag = 12'd1702;
      5'd4:    mag = 12'd1448;
      5'd5:    mag = 12'd1137;
      5'd6:    mag = 12'd783;
      5'd7:    mag = 12'd399;
      default: mag = 12'd0;
    endcase
    if (k == 3'd0) begin
      mag = 12'd1448;
      neg = 1'b0;
    end
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

endpackage

// File: rtl/compute_s_coeff_rom.sv
// Combinational DCT coefficient ROM: address {k,i} returns C[k][i].
module dct_coeff_rom
  import compute_s_pkg::*;
#(
  parameter int COEF_W = 12
) (
  input  logic        [5:0]        i_addr,
  output logic signed [COEF_W-1:0] o_coef
);

  logic signed [11:0] w_coef;

  assign w_coef = dctCoef(i_addr[5:3], i_addr[2:0]);
  assign o_coef = COEF_W'(w_coef);

endmodule

// File: rtl/compute_s.sv
// Second IDCT matrix stage: S = C^T * T, one MAC per clock, written element by
// element to port B of the S RAM.
module compute_s
  import compute_s_pkg::*;
#(
  parameter int COEF_W = 12,
  parameter int ACC_W  = 48
) (
  input  logic        Clock_50,
  input  logic        Resetn,
  input  logic        start,
  output logic        finish,
  output logic [6:0]  Address_T,
  input  logic [31:0] Data_out_T,
  output logic [6:0]  Address_S_b,
  output logic [31:0] Write_data_S_b,
  output logic        Write_enable_S_b
);

  localparam int PROD_W = 32 + COEF_W;

  state_t r_state, w_nextState;

  logic [2:0] r_k, r_j, r_i;
  logic [1:0] r_drainCnt;
  logic [$clog2(MAC_CYCLES)-1:0] w_issueIdx;
  logic w_lastAddr;
  logic w_inMac;

  logic       r_v1;
  logic [2:0] r_k1, r_i1, r_j1;

  logic                     r_v2, r_first2, r_last2;
  logic        [5:0]        r_e2;
  logic signed [PROD_W-1:0] r_prod;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [COEF_W-1:0] w_coef;

  logic signed [ACC_W-1:0] r_acc, w_accNext;
  logic        [31:0]      w_sat;
  logic                    r_we;
  logic        [6:0]       r_waddr;
  logic        [31:0]      r_wdata;

  assign w_inMac    = (r_state == S_MAC);
  assign w_issueIdx = {r_i, r_j, r_k};
  assign w_lastAddr = w_inMac && (w_issueIdx == $bits(w_issueIdx)'(MAC_CYCLES - 1));

  dct_coeff_rom #(.COEF_W(COEF_W)) u_rom (
    .i_addr (6'({r_k1, r_i1})),
    .o_coef (w_coef)
  );

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) r_state <= S_IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nextState = S_MAC;
      S_MAC:   if (w_lastAddr) w_nextState = S_DRAIN;
      S_DRAIN: if (r_drainCnt == 2'(PIPE_DEPTH - 1)) w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    Address_T = 7'd0;
    finish    = 1'b0;
    if (r_state == S_MAC)  Address_T = {1'b0, r_k, r_j};
    if (r_state == S_DONE) finish = 1'b1;
  end

  // Issue counters: k fastest, then j, then i; all wrap back to 0 after the last address.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_k        <= 3'd0;
      r_j        <= 3'd0;
      r_i        <= 3'd0;
      r_drainCnt <= 2'd0;
    end else begin
      if (w_inMac) begin
        r_k <= r_k + 3'd1;
        if (r_k == 3'(BLK_N - 1)) begin
          r_j <= r_j + 3'd1;
          if (r_j == 3'(BLK_N - 1)) r_i <= r_i + 3'd1;
        end
      end
      r_drainCnt <= (r_state == S_DRAIN) ? r_drainCnt + 2'd1 : 2'd0;
    end
  end

  assign w_prod = $signed(Data_out_T) * w_coef;

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_v1     <= 1'b0;
      r_k1     <= 3'd0;
      r_i1     <= 3'd0;
      r_j1     <= 3'd0;
      r_v2     <= 1'b0;
      r_first2 <= 1'b0;
      r_last2  <= 1'b0;
      r_e2     <= 6'd0;
      r_prod   <= '0;
    end else begin
      r_v1     <= w_inMac;
      r_k1     <= r_k;
      r_i1     <= r_i;
      r_j1     <= r_j;
      r_v2     <= r_v1;
      r_first2 <= (r_k1 == 3'd0);
      r_last2  <= (r_k1 == 3'(BLK_N - 1));
      r_e2     <= {r_i1, r_j1};
      r_prod   <= w_prod;
    end
  end

  assign w_accNext = r_first2 ? ACC_W'(r_prod) : r_acc + ACC_W'(r_prod);

  // Saturate when the bits above bit 31 are not a pure sign extension.
  always_comb begin
    w_sat = w_accNext[31:0];
    if (!w_accNext[ACC_W-1] && (|w_accNext[ACC_W-2:31]))
      w_sat = 32'h7FFF_FFFF;
    else if (w_accNext[ACC_W-1] && !(&w_accNext[ACC_W-2:31]))
      w_sat = 32'h8000_0000;
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_acc   <= '0;
      r_we    <= 1'b0;
      r_waddr <= 7'd0;
      r_wdata <= 32'd0;
    end else begin
      if (r_v2) r_acc <= w_accNext;
      r_we    <= r_v2 && r_last2;
      r_waddr <= (r_v2 && r_last2) ? {1'b0, r_e2} : 7'd0;
      r_wdata <= (r_v2 && r_last2) ? w_sat : 32'd0;
    end
  end

  assign Write_enable_S_b = r_we;
  assign Address_S_b      = r_waddr;
  assign Write_data_S_b   = r_wdata;

endmodule

// File: tb/tb_compute_s.sv
// Directed bench for compute_s: T RAM model, write/finish monitor, golden C^T*T model.
module tb_compute_s;

  logic        Clock_50 = 1'b0;
  logic        Resetn   = 1'b0;
  logic        start    = 1'b0;
  logic        finish;
  logic [6:0]  Address_T;
  logic [31:0] Data_out_T = 32'd0;
  logic [6:0]  Address_S_b;
  logic [31:0] Write_data_S_b;
  logic        Write_enable_S_b;

  compute_s dut (
    .Clock_50         (Clock_50),
    .Resetn           (Resetn),
    .start            (start),
    .finish           (finish),
    .Address_T        (Address_T),
    .Data_out_T       (Data_out_T),
    .Address_S_b      (Address_S_b),
    .Write_data_S_b   (Write_data_S_b),
    .Write_enable_S_b (Write_enable_S_b)
  );

  always #10 Clock_50 = ~Clock_50;

  localparam int CT[64] = '{
    1448,  1448,  1448,  1448,  1448,  1448,  1448,  1448,
    2008,  1702,  1137,   399,  -399, -1137, -1702, -2008,
    1892,   783,  -783, -1892, -1892,  -783,   783,  1892,
    1702,  -399, -2008, -1137,  1137,  2008,   399, -1702,
    1448, -1448, -1448,  1448,  1448, -1448, -1448,  1448,
    1137, -2008,   399,  1702, -1702,  -399,  2008, -1137,
     783, -1892,  1892,  -783,  -783,  1892, -1892,   783,
     399, -1137,  1702, -2008,  2008, -1702,  1137,  -399
  };

  int tMem[64];

  always @(posedge Clock_50) Data_out_T <= tMem[Address_T[5:0]];

  int          cycleCnt = 0;
  int          wrCount  = 0;
  int          finCount = 0;
  int          finCycle = 0;
  logic [6:0]  wrAddr [2048];
  logic [31:0] wrData [2048];
  int          wrCycle[2048];

  always @(negedge Clock_50) begin
    cycleCnt = cycleCnt + 1;
    if (Write_enable_S_b) begin
      wrAddr[wrCount]  = Address_S_b;
      wrData[wrCount]  = Write_data_S_b;
      wrCycle[wrCount] = cycleCnt;
      wrCount = wrCount + 1;
    end
    if (finish) begin
      finCount = finCount + 1;
      finCycle = cycleCnt;
    end
  end

  int         testsRun    = 0;
  int         testsFailed = 0;
  logic [6:0] addrAt2, addrAt9, addrAt517;

  function automatic logic [31:0] goldS(input int i, input int j);
    longint acc = 0;
    for (int k = 0; k < 8; k++) acc += longint'(CT[k*8+i]) * longint'(tMem[k*8+j]);
    if (acc > 64'sh7FFFFFFF) return 32'h7FFFFFFF;
    if (acc < -64'sh80000000) return 32'h80000000;
    return acc[31:0];
  endfunction

  // Pulse start at relative cycle 0, optionally re-pulse or drop Resetn later.
  task automatic runBlock(input int repulseAt, input int resetAt, output int base);
    @(negedge Clock_50); #1;
    base  = cycleCnt;
    start = 1'b1;
    for (int c = 1; c <= 560; c++) begin
      @(negedge Clock_50); #1;
      if (c == 1) start = 1'b0;
      if (c == 2) addrAt2 = Address_T;
      if (c == 9) addrAt9 = Address_T;
      if (c == 517) addrAt517 = Address_T;
      if (c == repulseAt) start = 1'b1;
      if (c == repulseAt + 1) start = 1'b0;
      if (c == resetAt) begin
        Resetn = 1'b0;
        #1;
        return;
      end
      if (c >= 518) return;
    end
  endtask

  task automatic test_reset;
    Resetn = 1'b0;
    start  = 1'b0;
    repeat (3) @(negedge Clock_50);
    #1;
    testsRun++;
    if (Address_T !== 7'd0) begin testsFailed++; $display("[TB] FAIL reset Address_T: got %0d expected 0", Address_T); end
    testsRun++;
    if (Write_enable_S_b !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset we: got %b expected 0", Write_enable_S_b); end
    testsRun++;
    if (Address_S_b !== 7'd0) begin testsFailed++; $display("[TB] FAIL reset Address_S_b: got %0d expected 0", Address_S_b); end
    testsRun++;
    if (Write_data_S_b !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset Write_data: got %h expected 0", Write_data_S_b); end
    testsRun++;
    if (finish !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset finish: got %b expected 0", finish); end
    Resetn = 1'b1;
    repeat (2) @(negedge Clock_50);
  endtask

  task automatic test_zero;
    int base, wb, fb;
    for (int n = 0; n < 64; n++) tMem[n] = 0;
    wb = wrCount; fb = finCount;
    runBlock(0, 0, base);
    testsRun++;
    if (wrCount - wb !== 64) begin testsFailed++; $display("[TB] FAIL zero write count: got %0d expected 64", wrCount - wb); end
    testsRun++;
    if (finCount - fb !== 1) begin testsFailed++; $display("[TB] FAIL zero finish count: got %0d expected 1", finCount - fb); end
    testsRun++;
    if (finCycle - base !== 516) begin testsFailed++; $display("[TB] FAIL zero finish cycle: got %0d expected 516", finCycle - base); end
    testsRun++;
    if (addrAt2 !== 7'd8) begin testsFailed++; $display("[TB] FAIL zero Address_T cycle2: got %0d expected 8", addrAt2); end
    testsRun++;
    if (addrAt9 !== 7'd1) begin testsFailed++; $display("[TB] FAIL zero Address_T cycle9: got %0d expected 1", addrAt9); end
    testsRun++;
    if (addrAt517 !== 7'd0) begin testsFailed++; $display("[TB] FAIL zero Address_T idle: got %0d expected 0", addrAt517); end
    for (int e = 0; e < 64; e++) begin
      testsRun++;
      if (wrAddr[wb+e] !== 7'(e) || wrData[wb+e] !== 32'd0 || wrCycle[wb+e] - base !== 8*e + 11) begin
        testsFailed++;
        $display("[TB] FAIL zero write %0d: got addr %0d data %h cycle %0d expected addr %0d data 0 cycle %0d",
                 e, wrAddr[wb+e], wrData[wb+e], wrCycle[wb+e] - base, e, 8*e + 11);
      end
    end
  endtask

  task automatic test_impulse;
    int base, wb;
    logic [31:0] expv;
    for (int n = 0; n < 64; n++) tMem[n] = 0;
    tMem[0] = 4096;
    wb = wrCount;
    runBlock(0, 0, base);
    testsRun++;
    if (wrCount - wb !== 64) begin testsFailed++; $display("[TB] FAIL impulse write count: got %0d expected 64", wrCount - wb); end
    for (int e = 0; e < 64; e++) begin
      expv = ((e % 8) == 0) ? 32'd5931008 : 32'd0;
      testsRun++;
      if (wrData[wb+e] !== expv) begin
        testsFailed++;
        $display("[TB] FAIL impulse S[%0d]: got %0d expected %0d", e, wrData[wb+e], expv);
      end
    end
  endtask

  task automatic test_saturation;
    int base, wb;
    for (int n = 0; n < 64; n++) tMem[n] = 1 << 20;
    wb = wrCount;
    runBlock(0, 0, base);
    testsRun++;
    if (wrCount - wb !== 64) begin testsFailed++; $display("[TB] FAIL possat write count: got %0d expected 64", wrCount - wb); end
    for (int e = 0; e < 64; e++) begin
      testsRun++;
      if (e < 8 && wrData[wb+e] !== 32'h7FFFFFFF) begin
        testsFailed++;
        $display("[TB] FAIL possat S[0][%0d]: got %h expected 7fffffff", e, wrData[wb+e]);
      end else if (e >= 8 && wrData[wb+e] !== goldS(e / 8, e % 8)) begin
        testsFailed++;
        $display("[TB] FAIL possat S[%0d]: got %h expected %h", e, wrData[wb+e], goldS(e / 8, e % 8));
      end
    end
    for (int n = 0; n < 64; n++) tMem[n] = -(1 << 20);
    wb = wrCount;
    runBlock(0, 0, base);
    testsRun++;
    if (wrCount - wb !== 64) begin testsFailed++; $display("[TB] FAIL negsat write count: got %0d expected 64", wrCount - wb); end
    for (int e = 0; e < 8; e++) begin
      testsRun++;
      if (wrData[wb+e] !== 32'h80000000) begin
        testsFailed++;
        $display("[TB] FAIL negsat S[0][%0d]: got %h expected 80000000", e, wrData[wb+e]);
      end
    end
  endtask

  task automatic test_random;
    int base, wb;
    for (int n = 0; n < 64; n++) tMem[n] = int'($urandom);
    tMem[5] = 32'sh7FFFFFFF;
    tMem[40] = 32'sh80000000;
    wb = wrCount;
    runBlock(0, 0, base);
    testsRun++;
    if (wrCount - wb !== 64) begin testsFailed++; $display("[TB] FAIL random write count: got %0d expected 64", wrCount - wb); end
    for (int e = 0; e < 64; e++) begin
      testsRun++;
      if (wrData[wb+e] !== goldS(e / 8, e % 8)) begin
        testsFailed++;
        $display("[TB] FAIL random S[%0d]: got %h expected %h", e, wrData[wb+e], goldS(e / 8, e % 8));
      end
    end
  endtask

  task automatic test_restart_ignored;
    int base, wb, fb;
    for (int n = 0; n < 64; n++) tMem[n] = int'($urandom_range(0, 65535)) - 32768;
    wb = wrCount; fb = finCount;
    runBlock(200, 0, base);
    repeat (20) @(negedge Clock_50);
    #1;
    testsRun++;
    if (wrCount - wb !== 64) begin testsFailed++; $display("[TB] FAIL restart write count: got %0d expected 64", wrCount - wb); end
    testsRun++;
    if (finCount - fb !== 1) begin testsFailed++; $display("[TB] FAIL restart finish count: got %0d expected 1", finCount - fb); end
    testsRun++;
    if (wrData[wb+63] !== goldS(7, 7)) begin
      testsFailed++;
      $display("[TB] FAIL restart S[63]: got %h expected %h", wrData[wb+63], goldS(7, 7));
    end
  endtask

  task automatic test_reset_mid;
    int base, wb, fb;
    for (int n = 0; n < 64; n++) tMem[n] = int'($urandom);
    wb = wrCount; fb = finCount;
    runBlock(0, 300, base);
    testsRun++;
    if (Address_T !== 7'd0 || Write_enable_S_b !== 1'b0 || Address_S_b !== 7'd0 ||
        Write_data_S_b !== 32'd0 || finish !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midreset outputs: got addrT %0d we %b addrS %0d data %h fin %b expected all 0",
               Address_T, Write_enable_S_b, Address_S_b, Write_data_S_b, finish);
    end
    repeat (3) @(negedge Clock_50);
    Resetn = 1'b1;
    repeat (30) @(negedge Clock_50);
    #1;
    testsRun++;
    if (wrCount - wb !== 37) begin testsFailed++; $display("[TB] FAIL midreset write count: got %0d expected 37", wrCount - wb); end
    testsRun++;
    if (finCount - fb !== 0) begin testsFailed++; $display("[TB] FAIL midreset finish count: got %0d expected 0", finCount - fb); end
    testsRun++;
    if (Address_T !== 7'd0) begin testsFailed++; $display("[TB] FAIL midreset idle Address_T: got %0d expected 0", Address_T); end
    wb = wrCount; fb = finCount;
    runBlock(0, 0, base);
    testsRun++;
    if (wrCount - wb !== 64) begin testsFailed++; $display("[TB] FAIL postreset write count: got %0d expected 64", wrCount - wb); end
    testsRun++;
    if (finCycle - base !== 516) begin testsFailed++; $display("[TB] FAIL postreset finish cycle: got %0d expected 516", finCycle - base); end
    for (int e = 0; e < 64; e++) begin
      testsRun++;
      if (wrAddr[wb+e] !== 7'(e) || wrData[wb+e] !== goldS(e / 8, e % 8)) begin
        testsFailed++;
        $display("[TB] FAIL postreset S[%0d]: got addr %0d data %h expected addr %0d data %h",
                 e, wrAddr[wb+e], wrData[wb+e], e, goldS(e / 8, e % 8));
      end
    end
  endtask

  initial begin
    for (int n = 0; n < 64; n++) tMem[n] = 0;
    test_reset();
    test_zero();
    test_impulse();
    test_saturation();
    test_random();
    test_restart_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
